addsub_share_arbiter: RTL and testbench
=======================================

# addsub_share_arbiter

Shares one 6-bit ripple add/subtract unit between two requesters, A and B. The block arbitrates between them round-robin or fixed-priority, registers the granted operands, runs the add or subtract, and holds the result with a valid/ready response handshake. It sits between two client FSMs and the single combinational add/sub datapath instance, which it contains. It also keeps a wrapping count of completed operations.

## Interface
- FAIR, default 1: 1 selects round-robin between A and B; 0 gives A fixed priority.
- CNT_W, default 8: width of the completed-operation counter.

- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  synchronous, active-low reset.
- req_a / req_b  in  1  operation request; held high until acknowledged.
- x_a, y_a / x_b, y_b  in  6  operands; valid while the matching req is high.
- sel_a / sel_b  in  1  operation select: 0 = x+y, 1 = x−y.
- ack_a / ack_b  out  1  request accepted; combinational, asserted only in IDLE.
- rsp_valid_a / rsp_valid_b  out  1  result valid for that requester.
- rsp_ready_a / rsp_ready_b  in  1  requester accepts the result.
- rsp_sum  out  6  shared result bus.
- rsp_cout  out  1  carry out of the MSB; for subtract, 1 means no borrow.
- rsp_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNT_W  number of completed response transfers; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no request is high, stay in IDLE.
  - Otherwise select a winner. Assert ack of the winner only, in the same cycle.
  - At the clock edge, latch x, y, sel and the owner identity into operand registers. Go to EXEC.
- Arbitration:
  - One requester active: it wins.
  - Both active, FAIR=1: the requester not granted last time wins. The last-grant register resets to "B", so A wins the first tie.
  - Both active, FAIR=0: A always wins.
  - The last-grant register updates on every grant.
- EXEC:
  - Drive the add/sub unit from the operand registers. The unit sees y XOR sel and carry-in = sel.
  - Register sum, cout and ovf into the result registers. Go to RESP.
- RESP:
  - Assert rsp_valid of the owner only. rsp_sum, rsp_cout and rsp_ovf stay stable.
  - Transfer happens on the edge where the owner's rsp_valid and rsp_ready are both high. At that edge, increment op_count and go to IDLE.
  - The non-owner's rsp_ready is ignored.
- No new grant is made outside IDLE. Requests raised during EXEC or RESP wait, with ack low.
- Arithmetic is 6-bit two's complement; results wrap modulo 64.
- Reset values: ack_a=ack_b=0, rsp_valid_a=rsp_valid_b=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, busy=0, op_count=0. State=IDLE, last-grant=B.
- rst_n low at any edge, including mid-EXEC or mid-RESP:
  - All registers take their reset values at that edge.
  - Any pending result is discarded, with no response transfer and no count.
  - rst_n has priority over every other event at that edge.

## Timing
- Cycle N: state IDLE, req_x high, ack_x high. Operands are captured at the end of N.
- Cycle N+1: EXEC, busy high.
- Cycle N+2: RESP, rsp_valid_x high, result registered and stable.
- If rsp_ready_x is high in N+2, IDLE is entered at N+3. Earliest next ack is in N+3.
- Minimum spacing between operations is 3 cycles. Latency from accept to rsp_valid is 2 cycles.
- Backpressure: RESP holds indefinitely while rsp_ready is low. rsp_* outputs do not change.
- op_count updates at the transfer edge; the new value is visible the following cycle. CNT_W all-ones + 1 wraps to 0.
- ack is a Mealy output of IDLE and the req inputs. Requesters must hold their operands stable while req is high.

## Test plan
- A alone, x=5, y=3, sel=0:
  - ack_a in N, rsp_valid_a in N+2.
  - sum=8, cout=0, ovf=0. op_count goes 0→1.
- A subtract, x=3, y=5, sel=1: sum=62 (0x3E), cout=0, ovf=0.
- Overflow on A:
  - x=31, y=1, sel=0: sum=32, cout=0, ovf=1.
  - x=32, y=1, sel=1: sum=31, cout=1, ovf=1.
- req_a and req_b held high continuously with rsp_ready high:
  - FAIR=1: grant order is A, B, A, B; each ack is 3 cycles apart.
  - FAIR=0: grants go only to A.
- B owns the result; rsp_ready_b is low for 5 cycles while req_a is high:
  - rsp_valid_b and rsp_sum stay stable; ack_a stays 0.
  - rsp_ready_a is ignored.
  - After rsp_ready_b rises, ack_a asserts one cycle after the transfer.
- Reset cases:
  - rst_n low for 1 cycle while in RESP: the next cycle shows all outputs 0, busy=0, op_count=0. A subsequent tie grants A.
  - 256 completed operations with CNT_W=8: op_count returns to 0.

Source files
------------

// File: rtl/addsub_share_arbiter_if.sv
// Request/response bundle between two requesters (A, B) and the shared
// add/sub arbiter.
//   req_*/x_*/y_*/sel_*  : operation request and operands, per requester
//   ack_*                : combinational accept, only in IDLE
//   rsp_valid_*/ready_*  : per-requester result handshake
//   rsp_sum/cout/ovf     : shared result bus
//   busy, op_count       : status
interface addsub_share_arbiter_if #(
  parameter int unsigned CNT_W = 8
);
  logic             req_a;
  logic             req_b;
  logic [5:0]       x_a;
  logic [5:0]       y_a;
  logic [5:0]       x_b;
  logic [5:0]       y_b;
  logic             sel_a;
  logic             sel_b;
  logic             ack_a;
  logic             ack_b;
  logic             rsp_valid_a;
  logic             rsp_valid_b;
  logic             rsp_ready_a;
  logic             rsp_ready_b;
  logic [5:0]       rsp_sum;
  logic             rsp_cout;
  logic             rsp_ovf;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  // Arbiter side
  modport slave (
    input  req_a, req_b, x_a, y_a, x_b, y_b, sel_a, sel_b,
    input  rsp_ready_a, rsp_ready_b,
    output ack_a, ack_b, rsp_valid_a, rsp_valid_b,
    output rsp_sum, rsp_cout, rsp_ovf, busy, op_count
  );

  // Requester side
  modport master (
    output req_a, req_b, x_a, y_a, x_b, y_b, sel_a, sel_b,
    output rsp_ready_a, rsp_ready_b,
    input  ack_a, ack_b, rsp_valid_a, rsp_valid_b,
    input  rsp_sum, rsp_cout, rsp_ovf, busy, op_count
  );
endinterface

// File: rtl/addsub_share_arbiter.sv
// Shares one 6-bit add/subtract unit between requesters A and B.
// Arbitrates (round-robin when FAIR=1, A-priority when FAIR=0), captures the
// winner's operands, computes in EXEC, and holds the result in RESP until
// the owner accepts it. Counts completed response transfers.
//   i_clk   : rising-edge clock
//   i_rst_n : synchronous active-low reset
//   bus     : request/response bundle (slave side)
module addsub_share_arbiter #(
  parameter bit          FAIR  = 1'b1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  addsub_share_arbiter_if.slave bus
);

  localparam int unsigned DW  = 6;
  localparam int unsigned DW1 = DW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_b;   // 1: most recent grant went to B
  logic             r_owner_b;  // 1: current operation belongs to B
  logic [DW-1:0]    r_x;
  logic [DW-1:0]    r_y;
  logic             r_sel;
  logic [DW-1:0]    r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;

  logic             w_grant_b;
  logic             w_ack_a;
  logic             w_ack_b;
  logic             w_xfer;
  logic [DW-1:0]    w_y_eff;
  logic [DW-1:0]    w_low;
  logic [DW:0]      w_full;

  // Winner selection; a tie under FAIR goes to whoever was not granted last
  always_comb begin
    w_grant_b = 1'b0;
    if (bus.req_a && bus.req_b) begin
      w_grant_b = FAIR ? !r_last_b : 1'b0;
    end else begin
      w_grant_b = bus.req_b;
    end
  end

  // Add/sub datapath: subtract is x + ~y + 1.
  // w_low isolates the carry into the MSB for the overflow flag.
  assign w_y_eff = r_y ^ {DW{r_sel}};
  assign w_low   = {1'b0, r_x[DW-2:0]} + {1'b0, w_y_eff[DW-2:0]} + DW'(r_sel);
  assign w_full  = {1'b0, r_x} + {1'b0, w_y_eff} + DW1'(r_sel);

  // Next-state and handshake decode
  always_comb begin
    w_next_state = r_state;
    w_ack_a      = 1'b0;
    w_ack_b      = 1'b0;
    w_xfer       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_a || bus.req_b) begin
          w_ack_a      = !w_grant_b;
          w_ack_b      = w_grant_b;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next_state = S_RESP;
      end
      S_RESP: begin
        w_xfer = r_owner_b ? bus.rsp_ready_b : bus.rsp_ready_a;
        if (w_xfer) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, operand, result and counter registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_last_b  <= 1'b1;
      r_owner_b <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_sel     <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (bus.req_a || bus.req_b) begin
            r_owner_b <= w_grant_b;
            r_last_b  <= w_grant_b;
            r_x       <= w_grant_b ? bus.x_b   : bus.x_a;
            r_y       <= w_grant_b ? bus.y_b   : bus.y_a;
            r_sel     <= w_grant_b ? bus.sel_b : bus.sel_a;
          end
        end
        S_EXEC: begin
          r_sum  <= w_full[DW-1:0];
          r_cout <= w_full[DW];
          r_ovf  <= w_low[DW-1] ^ w_full[DW];
        end
        S_RESP: begin
          if (w_xfer) begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ack_a       = w_ack_a;
  assign bus.ack_b       = w_ack_b;
  assign bus.rsp_valid_a = (r_state == S_RESP) && !r_owner_b;
  assign bus.rsp_valid_b = (r_state == S_RESP) && r_owner_b;
  assign bus.rsp_sum     = r_sum;
  assign bus.rsp_cout    = r_cout;
  assign bus.rsp_ovf     = r_ovf;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.op_count    = r_count;

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Directed bench for addsub_share_arbiter: one round-robin instance (f1) and
// one A-priority instance (f0) sharing clock and reset.
module tb_addsub_share_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt;

  always #5 clk = ~clk;

  addsub_share_arbiter_if #(.CNT_W(8)) f1 ();
  addsub_share_arbiter_if #(.CNT_W(8)) f0 ();

  addsub_share_arbiter #(.FAIR(1'b1), .CNT_W(8)) u_fair (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (f1.slave)
  );

  addsub_share_arbiter #(.FAIR(1'b0), .CNT_W(8)) u_prio (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (f0.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    f1.req_a = 0; f1.req_b = 0; f1.x_a = 0; f1.y_a = 0; f1.x_b = 0; f1.y_b = 0;
    f1.sel_a = 0; f1.sel_b = 0; f1.rsp_ready_a = 0; f1.rsp_ready_b = 0;
    f0.req_a = 0; f0.req_b = 0; f0.x_a = 0; f0.y_a = 0; f0.x_b = 0; f0.y_b = 0;
    f0.sel_a = 0; f0.sel_b = 0; f0.rsp_ready_a = 0; f0.rsp_ready_b = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  // Single operation from A on the fair instance, ready held high
  task automatic run_a(input logic [5:0] x, input logic [5:0] y, input logic s,
                       input logic [5:0] es, input logic ec, input logic eo);
    chk("cnt_before", 32'(f1.op_count), 32'(exp_cnt));
    f1.req_a = 1; f1.x_a = x; f1.y_a = y; f1.sel_a = s; f1.rsp_ready_a = 1;
    #1;
    chk("ack_a_idle", 32'(f1.ack_a), 32'd1);
    chk("busy_idle", 32'(f1.busy), 32'd0);
    tick();
    f1.req_a = 0;
    #1;
    chk("busy_exec", 32'(f1.busy), 32'd1);
    chk("valid_exec", 32'(f1.rsp_valid_a), 32'd0);
    tick();
    chk("valid_a_resp", 32'(f1.rsp_valid_a), 32'd1);
    chk("valid_b_resp", 32'(f1.rsp_valid_b), 32'd0);
    chk("sum", 32'(f1.rsp_sum), 32'(es));
    chk("cout", 32'(f1.rsp_cout), 32'(ec));
    chk("ovf", 32'(f1.rsp_ovf), 32'(eo));
    tick();
    exp_cnt++;
    chk("cnt_after", 32'(f1.op_count), 32'(exp_cnt));
    chk("busy_after", 32'(f1.busy), 32'd0);
  endtask

  logic grant_who [4];
  int   grant_t   [4];
  int   ng, na0, nb0;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    exp_cnt = 0;
    tick();
    tick();
    chk("rst_ack_a", 32'(f1.ack_a), 32'd0);
    chk("rst_valid_a", 32'(f1.rsp_valid_a), 32'd0);
    chk("rst_valid_b", 32'(f1.rsp_valid_b), 32'd0);
    chk("rst_sum", 32'(f1.rsp_sum), 32'd0);
    chk("rst_busy", 32'(f1.busy), 32'd0);
    chk("rst_cnt", 32'(f1.op_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Arithmetic on A
    run_a(6'd5,  6'd3, 1'b0, 6'd8,  1'b0, 1'b0);
    run_a(6'd3,  6'd5, 1'b1, 6'd62, 1'b0, 1'b0);
    run_a(6'd31, 6'd1, 1'b0, 6'd32, 1'b0, 1'b1);
    run_a(6'd32, 6'd1, 1'b1, 6'd31, 1'b1, 1'b1);

    // Continuous tie on both instances from reset
    do_reset();
    f1.req_a = 1; f1.req_b = 1; f1.x_a = 1; f1.y_a = 1; f1.x_b = 2; f1.y_b = 2;
    f1.rsp_ready_a = 1; f1.rsp_ready_b = 1;
    f0.req_a = 1; f0.req_b = 1; f0.x_a = 1; f0.y_a = 1; f0.x_b = 2; f0.y_b = 2;
    f0.rsp_ready_a = 1; f0.rsp_ready_b = 1;
    #1;
    ng = 0; na0 = 0; nb0 = 0;
    for (int c = 0; c < 12; c++) begin
      if (f1.ack_a || f1.ack_b) begin
        if (ng < 4) begin
          grant_who[ng] = f1.ack_b;
          grant_t[ng]   = c;
        end
        ng++;
      end
      if (f0.ack_a) na0++;
      if (f0.ack_b) nb0++;
      tick();
    end
    idle_inputs();
    chk("rr_grants", 32'(ng), 32'd4);
    chk("rr_g0_is_b", 32'(grant_who[0]), 32'd0);
    chk("rr_g1_is_b", 32'(grant_who[1]), 32'd1);
    chk("rr_g2_is_b", 32'(grant_who[2]), 32'd0);
    chk("rr_g3_is_b", 32'(grant_who[3]), 32'd1);
    chk("rr_gap1", 32'(grant_t[1] - grant_t[0]), 32'd3);
    chk("rr_gap2", 32'(grant_t[2] - grant_t[1]), 32'd3);
    chk("rr_gap3", 32'(grant_t[3] - grant_t[2]), 32'd3);
    chk("prio_a_grants", 32'(na0), 32'd4);
    chk("prio_b_grants", 32'(nb0), 32'd0);
    exp_cnt = 4;
    chk("rr_cnt", 32'(f1.op_count), 32'(exp_cnt));

    // Backpressure on B with A waiting
    f1.req_b = 1; f1.x_b = 10; f1.y_b = 20; f1.sel_b = 0;
    f1.rsp_ready_b = 0; f1.rsp_ready_a = 1;
    #1;
    chk("bp_ack_b", 32'(f1.ack_b), 32'd1);
    tick();
    f1.req_b = 0;
    f1.req_a = 1; f1.x_a = 7; f1.y_a = 9; f1.sel_a = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_b", 32'(f1.rsp_valid_b), 32'd1);
      chk("bp_valid_a", 32'(f1.rsp_valid_a), 32'd0);
      chk("bp_sum", 32'(f1.rsp_sum), 32'd30);
      chk("bp_ack_a", 32'(f1.ack_a), 32'd0);
      tick();
    end
    chk("bp_cnt_held", 32'(f1.op_count), 32'(exp_cnt));
    f1.rsp_ready_b = 1;
    #1;
    chk("bp_valid_b_last", 32'(f1.rsp_valid_b), 32'd1);
    tick();
    exp_cnt++;
    chk("bp_ack_a_after", 32'(f1.ack_a), 32'd1);
    chk("bp_cnt", 32'(f1.op_count), 32'(exp_cnt));
    tick();
    f1.req_a = 0;
    tick();
    chk("bp_a_valid", 32'(f1.rsp_valid_a), 32'd1);
    chk("bp_a_sum", 32'(f1.rsp_sum), 32'd62);
    chk("bp_a_cout", 32'(f1.rsp_cout), 32'd0);
    tick();
    exp_cnt++;
    chk("bp_a_cnt", 32'(f1.op_count), 32'(exp_cnt));
    f1.rsp_ready_b = 0;

    // Reset while holding a result in RESP
    f1.req_a = 1; f1.x_a = 1; f1.y_a = 2; f1.sel_a = 0; f1.rsp_ready_a = 0;
    tick();
    f1.req_a = 0;
    tick();
    chk("rr_resp_valid", 32'(f1.rsp_valid_a), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    chk("mr_valid_a", 32'(f1.rsp_valid_a), 32'd0);
    chk("mr_sum", 32'(f1.rsp_sum), 32'd0);
    chk("mr_cout", 32'(f1.rsp_cout), 32'd0);
    chk("mr_ovf", 32'(f1.rsp_ovf), 32'd0);
    chk("mr_busy", 32'(f1.busy), 32'd0);
    chk("mr_cnt", 32'(f1.op_count), 32'd0);
    f1.rsp_ready_a = 1; f1.rsp_ready_b = 1;
    f1.req_a = 1; f1.req_b = 1;
    #1;
    chk("mr_tie_ack_a", 32'(f1.ack_a), 32'd1);
    chk("mr_tie_ack_b", 32'(f1.ack_b), 32'd0);
    tick();
    f1.req_a = 0; f1.req_b = 0;
    tick();
    tick();
    exp_cnt++;
    chk("mr_tie_cnt", 32'(f1.op_count), 32'(exp_cnt));

    // Counter wrap: 255 more operations
    f1.req_a = 1; f1.x_a = 2; f1.y_a = 3; f1.sel_a = 0;
    for (int i = 0; i < 3 * 254; i++) tick();
    chk("wrap_255", 32'(f1.op_count), 32'd255);
    tick();
    tick();
    tick();
    f1.req_a = 0;
    chk("wrap_0", 32'(f1.op_count), 32'd0);
    tick();
    chk("wrap_idle", 32'(f1.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
